// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipeline hazard / forwarding logic.
//   FWD_RF            forward-select code meaning "use the register file";
//                     any other code k selects tracked stage k.
//   MAX_REG_ADDR_WIDTH widest register index a tracking entry can hold.
//                     Narrower indices are zero-extended into it, which
//                     leaves equality compares unchanged.
//   track_entry_t     one tracked in-flight instruction.
//   entry_matches()   true when an entry will write the given source register.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int FWD_RF             = 0;
  localparam int MAX_REG_ADDR_WIDTH = 8;

  typedef logic [MAX_REG_ADDR_WIDTH-1:0] reg_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     reg_write;
    logic     is_load;
  } track_entry_t;

  // x0 is hard-wired to zero, so a write to it never produces a value.
  function automatic logic entry_matches(input track_entry_t e, input reg_idx_t src);
    return e.valid && e.reg_write && (e.rd != '0) && (e.rd == src);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk    rising-edge clock
//   rst    asynchronous active-high reset, clears count
//   clr    synchronous clear, wins over inc
//   inc    add one on this edge (ignored once saturated)
//   count  current value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// ---------------------------------------------------------------------------
// hazard_fwd_unit
// Tracks the instructions in the stages after decode (index 0 = E,
// NUM_STAGES-1 = W), detects load-use hazards, selects forwarding sources
// for the E operands, and counts stall / flush cycles.
//   clk, rst                      clock, async active-high reset
//   issue_valid_d                 decode holds a real instruction
//   rs1_d, rs2_d, rd_d            decode register indices
//   reg_write_d, is_load_d        decode writes rd / is a load
//   pc_src_e                      redirect taken in E
//   cnt_clr                       synchronous clear of both counters
//   stall_f, stall_d              hold fetch / decode (load-use)
//   flush_d, flush_e              squash decode / bubble into E
//   forward_a_e, forward_b_e      operand source: 0 = reg file, k = stage k
//   stall_cnt, flush_cnt          saturating performance counters
// ---------------------------------------------------------------------------
module hazard_fwd_unit
  import cpu_pkg::*;
#(
  parameter  int REG_ADDR_WIDTH = 5,
  parameter  int NUM_STAGES     = 3,
  parameter  int CNT_WIDTH      = 32,
  localparam int FWD_WIDTH      = $clog2(NUM_STAGES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      issue_valid_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d,
  input  logic                      reg_write_d,
  input  logic                      is_load_d,
  input  logic                      pc_src_e,
  input  logic                      cnt_clr,
  output logic                      stall_f,
  output logic                      stall_d,
  output logic                      flush_d,
  output logic                      flush_e,
  output logic [FWD_WIDTH-1:0]      forward_a_e,
  output logic [FWD_WIDTH-1:0]      forward_b_e,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  track_entry_t entry [NUM_STAGES];
  track_entry_t entry0_next;
  reg_idx_t     rs1_x;
  reg_idx_t     rs2_x;
  logic         lw_stall;

  assign rs1_x = reg_idx_t'(rs1_d);
  assign rs2_x = reg_idx_t'(rs2_d);

  // A load one stage ahead cannot forward in time; hold decode one cycle.
  assign lw_stall = issue_valid_d && entry[0].is_load &&
                    (entry_matches(entry[0], rs1_x) || entry_matches(entry[0], rs2_x));

  // A redirect discards decode anyway, so it overrides the stall. The rst
  // term keeps every output at zero while reset is held.
  assign stall_f = lw_stall & ~pc_src_e & ~rst;
  assign stall_d = stall_f;
  assign flush_d = pc_src_e & ~rst;
  assign flush_e = (pc_src_e | lw_stall) & ~rst;

  always_comb begin
    entry0_next           = '0;
    if (!flush_e) begin
      entry0_next.valid     = issue_valid_d;
      entry0_next.rd        = reg_idx_t'(rd_d);
      entry0_next.rs1       = rs1_x;
      entry0_next.rs2       = rs2_x;
      entry0_next.reg_write = reg_write_d;
      entry0_next.is_load   = is_load_d;
    end
  end

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    track_entry_t entry_q;

    // NOTE: tracking entries are reset (not left as uninitialised storage)
    // because a stale valid bit would create false forwarding after reset.
    if (i == 0) begin : g_head
      always_ff @(posedge clk or posedge rst) begin
        if (rst) entry_q <= '0;
        else     entry_q <= entry0_next;
      end
    end else begin : g_tail
      always_ff @(posedge clk or posedge rst) begin
        if (rst) entry_q <= '0;
        else     entry_q <= entry[i-1];
      end
    end

    assign entry[i] = entry_q;
  end

  // Scan oldest to youngest so the youngest matching producer wins.
  // NOTE: both outputs get a default before any conditional write so the
  // block stays purely combinational (no latch).
  always_comb begin
    forward_a_e = FWD_WIDTH'(FWD_RF);
    forward_b_e = FWD_WIDTH'(FWD_RF);
    if (entry[0].valid) begin
      for (int k = NUM_STAGES - 1; k >= 1; k--) begin
        if (entry_matches(entry[k], entry[0].rs1)) forward_a_e = FWD_WIDTH'(k);
        if (entry_matches(entry[k], entry[0].rs2)) forward_b_e = FWD_WIDTH'(k);
      end
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (stall_d),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (flush_d),
    .count (flush_cnt)
  );

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5, sets the architectural register index width.
REQ-002 Parameter NUM_STAGES, default 3, sets the number of tracked stages after decode; index 0 is E, index NUM_STAGES-1 is W; legal range 2..8.
REQ-003 Parameter CNT_WIDTH, default 32, sets the width of each performance counter.
REQ-004 Localparam FWD_WIDTH SHALL equal clog2(NUM_STAGES).
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 issue_valid_d  input  1  decode holds a real instruction.
REQ-008 rs1_d, rs2_d, rd_d  input  REG_ADDR_WIDTH each  decode source and destination indices.
REQ-009 reg_write_d, is_load_d  input  1 each  decode instruction writes rd / is a load.
REQ-010 pc_src_e  input  1  execute redirect (taken branch or jump).
REQ-011 cnt_clr  input  1  synchronous clear of both counters.
REQ-012 stall_f, stall_d, flush_d, flush_e  output  1 each  pipeline control.
REQ-013 forward_a_e, forward_b_e  output  FWD_WIDTH each  E operand source: 0 = register file, k = tracked stage k.
REQ-014 stall_cnt, flush_cnt  output  CNT_WIDTH each  performance counters.

Function
REQ-015 The block SHALL hold one tracking entry per stage {valid, rd, rs1, rs2, reg_write, is_load}.
REQ-016 Each rising edge, entry[i] SHALL load entry[i-1] for i>=1, and entry[0] SHALL load the decode fields with valid=issue_valid_d, or an invalid bubble when flush_e=1.
REQ-017 An entry SHALL match a source only if valid=1, reg_write=1, rd!=0, and rd equals that source.
REQ-018 lw_stall SHALL be 1 when issue_valid_d=1 and entry[0] is a matching load for rs1_d or rs2_d.
REQ-019 stall_f and stall_d SHALL equal lw_stall AND NOT pc_src_e.
REQ-020 flush_d SHALL equal pc_src_e; flush_e SHALL equal pc_src_e OR lw_stall.
REQ-021 forward_a_e SHALL be the smallest k in 1..NUM_STAGES-1 where entry[k] matches entry[0].rs1, else 0; forward_b_e is the same for rs2.
REQ-022 Both forward outputs SHALL be 0 when entry[0].valid=0.
REQ-023 Stall and flush outputs SHALL be combinational, with zero-cycle latency to inputs; forward outputs SHALL depend only on registered state.
REQ-024 stall_cnt SHALL increment by 1 on each edge where stall_d=1.
REQ-025 flush_cnt SHALL increment by 1 on each edge where flush_d=1.
REQ-026 Both counters SHALL saturate at all-ones with no wrap.
REQ-027 cnt_clr=1 SHALL zero both counters on the next edge and SHALL take priority over any increment in that cycle.
REQ-028 When lw_stall and pc_src_e occur together, the redirect SHALL win: no stall, entry[0] becomes a bubble, flush_d=1, and only flush_cnt increments.

Reset
REQ-029 While rst=1, all entries SHALL be invalid, both counters 0, and all outputs 0, independent of clk.
REQ-030 Deassertion of rst in mid-operation SHALL resume from the empty state with no stale forwarding.

Structure
REQ-031 Package cpu_pkg SHALL hold the forward-select encoding constants (FWD_RF=0) and the tracking-entry struct typedef.
REQ-032 A sub-module sat_counter (parameter WIDTH; ports clk, rst, clr, inc, count) SHALL be instantiated once for each counter.
REQ-033 The tracking array SHALL be built with a generate loop over NUM_STAGES; no stage count is hard-coded.

Verification
REQ-034 lw x5 then add x6,x5,x1 back-to-back -> one cycle with stall_f=stall_d=flush_e=1, then forward_a_e=2 (NUM_STAGES=3), stall_cnt=1.
REQ-035 add x5 then sub x7,x5,x5 -> forward_a_e=forward_b_e=1 next cycle, no stall.
REQ-036 Writes to x5 in stages 1 and 2 at once, E reads x5 -> forward_a_e=1 (youngest wins); same sequence with rd=x0 -> forward 0.
REQ-037 Load-use hazard with pc_src_e=1 in the same cycle -> stall 0, flush_d=flush_e=1, flush_cnt+1, stall_cnt unchanged.
REQ-038 CNT_WIDTH=4, 20 stall cycles -> stall_cnt holds 15; cnt_clr with a stall in the same cycle -> 0.
REQ-039 rst asserted between edges with entries valid -> outputs 0 immediately; after release, a dependent instruction forwards 0.
